// File: rtl/pipe_stage_skid.sv
// Decode-to-execute pipeline stage: ctrl/data bundles over valid/ready, optional
// two-entry skid buffer, hazard stall/flush, zero-control bubbles, bubble counter.
module pipe_stage_skid #(
    parameter int unsigned CTRL_W            = 24,
    parameter int unsigned DATA_W            = 128,
    parameter int unsigned SKID_EN           = 1,
    parameter int unsigned CLR_DATA_ON_FLUSH = 0,
    parameter int unsigned CNT_W             = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic              stall,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  bubble_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_FULL  = 2'b11
    } state_t;

    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic [DATA_W-1:0] data;
    } item_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t            state_q, state_d;
    item_t             main_q, main_d;
    item_t             skid_q, skid_d;
    item_t             in_item;
    logic [CNT_W-1:0]  bubble_q, bubble_d;
    logic              main_v, skid_v;
    logic              ready_raw;
    logic              acc, snd;

    assign main_v  = (state_q != ST_EMPTY);
    assign skid_v  = (state_q == ST_FULL);
    assign in_item = '{ctrl: in_ctrl, data: in_data};

    // With the skid buffer ready depends only on local state; without it, ready looks through to out_ready.
    always_comb begin
        ready_raw = 1'b0;
        if (SKID_EN != 0) begin
            ready_raw = ~skid_v;
        end else begin
            ready_raw = ~main_v | out_ready;
        end
        in_ready = ready_raw & ~stall & ~flush & ~rst;
    end

    assign acc = in_valid & in_ready;
    assign snd = main_v & out_ready & ~stall;

    // Next-state and datapath; ctrl of any slot that empties is cleared so bubbles are NOPs.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d     = ST_EMPTY;
            main_d.ctrl = '0;
            skid_d.ctrl = '0;
            if (CLR_DATA_ON_FLUSH != 0) begin
                main_d.data = '0;
                skid_d.data = '0;
            end
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (acc) begin
                        main_d  = in_item;
                        state_d = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (acc && snd) begin
                        main_d = in_item;
                    end else if (acc && (SKID_EN != 0)) begin
                        skid_d  = in_item;
                        state_d = ST_FULL;
                    end else if (snd) begin
                        main_d.ctrl = '0;
                        state_d     = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (snd) begin
                        main_d      = skid_q;
                        skid_d.ctrl = '0;
                        state_d     = ST_ONE;
                    end
                end
                default: begin
                    state_d     = ST_EMPTY;
                    main_d.ctrl = '0;
                    skid_d.ctrl = '0;
                end
            endcase
        end
    end

    // Saturating count of cycles presenting no valid item.
    always_comb begin
        bubble_d = bubble_q;
        if (!main_v && (bubble_q != CNT_MAX)) begin
            bubble_d = bubble_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_EMPTY;
            main_q   <= '0;
            skid_q   <= '0;
            bubble_q <= '0;
        end else begin
            state_q  <= state_d;
            main_q   <= main_d;
            skid_q   <= skid_d;
            bubble_q <= bubble_d;
        end
    end

    assign out_valid  = main_v;
    assign out_ctrl   = main_q.ctrl;
    assign out_data   = main_q.data;
    assign occupancy  = {1'b0, main_v} + {1'b0, skid_v};
    assign bubble_cnt = bubble_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: three configurations driven in lockstep, each checked
// every cycle against a FIFO-level reference model.
module tb_pipe_stage_skid;

    localparam int unsigned CTRL_W = 24;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned NDUT   = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst, in_valid, stall, flush, out_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data;

    logic              ir  [NDUT];
    logic              ov  [NDUT];
    logic [CTRL_W-1:0] oc  [NDUT];
    logic [DATA_W-1:0] od  [NDUT];
    logic [1:0]        occ [NDUT];
    logic [3:0]        bc_a;
    logic [15:0]       bc_b, bc_c;

    // a: skid, data kept on flush, 4-bit counter; b: skid, data cleared on flush; c: no skid
    pipe_stage_skid #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .SKID_EN(1), .CLR_DATA_ON_FLUSH(0), .CNT_W(4)) u_dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]), .in_ctrl(in_ctrl), .in_data(in_data),
        .stall(stall), .flush(flush), .out_valid(ov[0]), .out_ready(out_ready), .out_ctrl(oc[0]),
        .out_data(od[0]), .occupancy(occ[0]), .bubble_cnt(bc_a));
    pipe_stage_skid #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .SKID_EN(1), .CLR_DATA_ON_FLUSH(1), .CNT_W(16)) u_dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]), .in_ctrl(in_ctrl), .in_data(in_data),
        .stall(stall), .flush(flush), .out_valid(ov[1]), .out_ready(out_ready), .out_ctrl(oc[1]),
        .out_data(od[1]), .occupancy(occ[1]), .bubble_cnt(bc_b));
    pipe_stage_skid #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .SKID_EN(0), .CLR_DATA_ON_FLUSH(0), .CNT_W(16)) u_dut_c (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[2]), .in_ctrl(in_ctrl), .in_data(in_data),
        .stall(stall), .flush(flush), .out_valid(ov[2]), .out_ready(out_ready), .out_ctrl(oc[2]),
        .out_data(od[2]), .occupancy(occ[2]), .bubble_cnt(bc_c));

    int          cap  [NDUT] = '{2, 2, 1};
    bit          clr  [NDUT] = '{1'b0, 1'b1, 1'b0};
    int unsigned cmax [NDUT] = '{15, 65535, 65535};

    // Reference model: a FIFO of up to cap items per instance plus the last data shown.
    logic [CTRL_W-1:0] m_ctrl [NDUT][2];
    logic [DATA_W-1:0] m_data [NDUT][2];
    int                m_n    [NDUT];
    logic [DATA_W-1:0] m_last [NDUT];
    int unsigned       m_bub  [NDUT];

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit m_ready(input int i);
        if (rst || stall || flush) return 1'b0;
        if (cap[i] == 2) return (m_n[i] < 2);
        return (m_n[i] == 0) || out_ready;
    endfunction

    function automatic logic [15:0] bub_of(input int i);
        case (i)
            0:       return 16'(bc_a);
            1:       return bc_b;
            default: return bc_c;
        endcase
    endfunction

    task automatic set_in(input bit r, input bit iv, input logic [CTRL_W-1:0] c,
                          input logic [DATA_W-1:0] d, input bit st, input bit fl, input bit ordy);
        rst = r; in_valid = iv; in_ctrl = c; in_data = d; stall = st; flush = fl; out_ready = ordy;
    endtask

    task automatic check_all();
        #1;
        for (int i = 0; i < int'(NDUT); i++) begin
            check($sformatf("d%0d.in_ready", i), 64'(ir[i]), 64'(m_ready(i)));
            check($sformatf("d%0d.out_valid", i), 64'(ov[i]), 64'(m_n[i] > 0));
            check($sformatf("d%0d.out_ctrl", i), 64'(oc[i]), (m_n[i] > 0) ? 64'(m_ctrl[i][0]) : 64'(0));
            check($sformatf("d%0d.out_data", i), 64'(od[i]), (m_n[i] > 0) ? 64'(m_data[i][0]) : 64'(m_last[i]));
            check($sformatf("d%0d.occupancy", i), 64'(occ[i]), 64'(m_n[i]));
            check($sformatf("d%0d.bubble_cnt", i), 64'(bub_of(i)), 64'(m_bub[i]));
        end
    endtask

    task automatic step();
        bit                acc [NDUT];
        bit                snd [NDUT];
        bit                r, fl;
        logic [CTRL_W-1:0] c;
        logic [DATA_W-1:0] d;
        for (int i = 0; i < int'(NDUT); i++) begin
            acc[i] = in_valid && m_ready(i);
            snd[i] = (m_n[i] > 0) && out_ready && !stall;
        end
        r = rst; fl = flush; c = in_ctrl; d = in_data;
        @(posedge clk);
        for (int i = 0; i < int'(NDUT); i++) begin
            if (r) begin
                m_n[i] = 0; m_last[i] = '0; m_bub[i] = 0;
            end else begin
                if (m_n[i] == 0 && m_bub[i] < cmax[i]) m_bub[i]++;
                if (fl) begin
                    if (m_n[i] > 0) m_last[i] = m_data[i][0];
                    if (clr[i]) m_last[i] = '0;
                    m_n[i] = 0;
                end else begin
                    if (snd[i]) begin
                        if (m_n[i] == 1) m_last[i] = m_data[i][0];
                        m_ctrl[i][0] = m_ctrl[i][1];
                        m_data[i][0] = m_data[i][1];
                        m_n[i]--;
                    end
                    if (acc[i]) begin
                        m_ctrl[i][m_n[i]] = c;
                        m_data[i][m_n[i]] = d;
                        m_n[i]++;
                    end
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic cycle(input bit r, input bit iv, input logic [CTRL_W-1:0] c,
                         input logic [DATA_W-1:0] d, input bit st, input bit fl, input bit ordy);
        set_in(r, iv, c, d, st, fl, ordy);
        check_all();
        step();
    endtask

    initial begin
        for (int i = 0; i < int'(NDUT); i++) begin
            m_n[i] = 0; m_last[i] = '0; m_bub[i] = 0;
            m_ctrl[i][0] = '0; m_ctrl[i][1] = '0; m_data[i][0] = '0; m_data[i][1] = '0;
        end
        @(negedge clk);
        set_in(1, 0, '0, '0, 0, 0, 0);
        step();
        cycle(1, 1, 24'h9, $urandom, 0, 0, 1);

        // streaming at full throughput
        cycle(0, 1, 24'h1, $urandom, 0, 0, 1);
        cycle(0, 1, 24'h2, $urandom, 0, 0, 1);
        cycle(0, 1, 24'h3, $urandom, 0, 0, 1);
        cycle(0, 0, '0, '0, 0, 0, 1);
        cycle(0, 0, '0, '0, 0, 0, 1);

        // backpressure fills the skid entry
        cycle(0, 1, 24'hA, $urandom, 0, 0, 0);
        cycle(0, 1, 24'hB, $urandom, 0, 0, 0);
        check("bp_occ", 64'(occ[0]), 64'd2);
        check("bp_ready", 64'(ir[0]), 64'd0);
        cycle(0, 0, '0, '0, 0, 0, 0);
        repeat (3) cycle(0, 0, '0, '0, 0, 0, 1);

        // stall holds the output item
        cycle(0, 1, 24'h55, $urandom, 0, 0, 0);
        repeat (3) cycle(0, 1, 24'h77, $urandom, 1, 0, 1);
        check("stall_ctrl", 64'(oc[0]), 64'h55);
        repeat (2) cycle(0, 0, '0, '0, 0, 0, 1);

        // flush wins over stall
        cycle(0, 1, 24'h11, $urandom, 0, 0, 0);
        cycle(0, 1, 24'h22, $urandom, 0, 0, 0);
        cycle(0, 1, 24'h33, $urandom, 1, 1, 0);
        check("flush_ctrl", 64'(oc[0]), 64'd0);
        check("flush_clr_data", 64'(od[1]), 64'd0);
        cycle(0, 0, '0, '0, 0, 0, 1);

        // bubble counter saturation and clear
        cycle(1, 0, '0, '0, 0, 0, 0);
        repeat (20) cycle(0, 0, '0, '0, 0, 0, 0);
        check("bub_sat", 64'(bc_a), 64'd15);
        cycle(1, 0, '0, '0, 0, 0, 0);
        check("bub_clr", 64'(bc_a), 64'd0);

        // combinational ready path without skid buffer
        cycle(0, 1, 24'h66, $urandom, 0, 0, 0);
        set_in(0, 1, 24'h67, $urandom, 0, 0, 0);
        #1;
        check("c_ready_lo", 64'(ir[2]), 64'd0);
        out_ready = 1'b1;
        check_all();
        check("c_ready_hi", 64'(ir[2]), 64'd1);
        step();
        check("c_occ", 64'(occ[2]), 64'd1);
        check("c_ctrl", 64'(oc[2]), 64'h67);

        // randomized traffic
        repeat (3000) begin
            cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) < 7), CTRL_W'($urandom),
                  $urandom, ($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0),
                  ($urandom_range(0, 9) < 6));
        end
        check_all();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
